// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the phase-1 control sequencer.
// Includes the state encoding, opcode constants and IR field positions.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_T5    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_OP_MIN = 5'b00000;
  localparam logic [4:0] ALU_OP_MAX = 5'b01100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  // Offset form keeps the range test free of an always-true lower compare.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op - ALU_OP_MIN) <= (ALU_OP_MAX - ALU_OP_MIN);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register field plus an enable into a one-hot GPR select.
// Fields that name a register beyond NUM_REGS produce an all-zero select.
module reg_select_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          field,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = en && (32'(field) == i);
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired fetch / three-register ALU execute sequencer with wait states,
// halt/stop handling and a retired-instruction counter; Moore outputs.
module cpu_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  input  logic                run,
  input  logic                stop,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] rin_sel,
  output logic [NUM_REGS-1:0] rout_sel,
  output logic [4:0]          alu_op,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t     state;
  logic       first_t1;
  logic       pending;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       alu_ok;
  logic       rout_en;
  logic [3:0] rout_field;
  logic       unused_ir;

  assign opcode    = ir[OPC_HI:OPC_LO];
  assign ra        = ir[RA_HI:RA_LO];
  assign rb        = ir[RB_HI:RB_LO];
  assign rc        = ir[RC_HI:RC_LO];
  assign alu_ok    = is_alu_op(opcode);
  assign unused_ir = ^ir[RC_LO-1:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= S_RESET;
      first_t1    <= 1'b0;
      pending     <= 1'b0;
      instr_count <= '0;
    end else begin
      // Sticky stop; the HALT-entry branches below override this set.
      if (stop) pending <= 1'b1;
      case (state)
        S_RESET: state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          first_t1 <= 1'b1;
        end
        S_T1: begin
          first_t1 <= 1'b0;
          if (mem_ready) state <= S_T2;
        end
        S_T2: state <= S_T3;
        S_T3: begin
          if (alu_ok) begin
            state <= S_T4;
          end else if (opcode == OP_HALT) begin
            state   <= S_HALT;
            pending <= 1'b0;
          end else begin
            state <= S_T0;
          end
        end
        S_T4: state <= S_T5;
        S_T5: begin
          instr_count <= instr_count + 1'b1;
          if (pending) begin
            state   <= S_HALT;
            pending <= 1'b0;
          end else begin
            state <= S_T0;
          end
        end
        S_HALT: if (run) state <= S_T0;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    alu_op  = 5'd0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = first_t1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Yin     = alu_ok;
        illegal = !alu_ok && (opcode != OP_HALT);
      end
      S_T4: begin
        Zin    = 1'b1;
        alu_op = opcode;
      end
      S_T5:    Zlowout = 1'b1;
      S_HALT:  halted  = 1'b1;
      default: ;
    endcase
  end

  assign rout_en    = ((state == S_T3) && alu_ok) || (state == S_T4);
  assign rout_field = (state == S_T4) ? rc : rb;

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .field (ra),
    .en    (state == S_T5),
    .sel   (rin_sel)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .field (rout_field),
    .en    (rout_en),
    .sel   (rout_sel)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: per-cycle vector table plus
// hand-written reset-abort and counter-wrap sequences.
module tb_cpu_control_unit;
  import cpu_defs_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 4;

  localparam logic [31:0] IR_AND  = 32'h2891_8000; // and R1,R2,R3
  localparam logic [31:0] IR_ADD  = 32'h1A2B_0000; // add R4,R5,R6
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;
  localparam logic [31:0] IR_SUB  = 32'h23C4_8000; // sub R7,R8,R9
  localparam logic [31:0] IR_OR   = 32'h355E_0000; // or R10,R11,R12

  // {PCout,Zlowout,MDRout,MARin,PCin,MDRin,IRin,Yin,Zin,IncPC,Read,halted,illegal}
  localparam logic [12:0] C_T0   = 13'h1218;
  localparam logic [12:0] C_T1F  = 13'h0984;
  localparam logic [12:0] C_T1   = 13'h0884;
  localparam logic [12:0] C_T2   = 13'h0440;
  localparam logic [12:0] C_T3   = 13'h0020;
  localparam logic [12:0] C_T4   = 13'h0010;
  localparam logic [12:0] C_T5   = 13'h0800;
  localparam logic [12:0] C_HALT = 13'h0002;
  localparam logic [12:0] C_ILL  = 13'h0001;
  localparam logic [12:0] C_NONE = 13'h0000;

  logic                clock = 1'b0;
  logic                clear;
  logic [31:0]         ir;
  logic                mem_ready, run, stop;
  logic                PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
  logic                Yin, Zin, IncPC, Read, halted, illegal;
  logic [NUM_REGS-1:0] rin_sel, rout_sel;
  logic [4:0]          alu_op;
  logic [CNT_W-1:0]    instr_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cpu_control_unit #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .run(run), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .IncPC(IncPC), .Read(Read), .rin_sel(rin_sel), .rout_sel(rout_sel),
    .alu_op(alu_op), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  typedef struct {
    logic        mr;
    logic        rn;
    logic        sp;
    logic [31:0] irv;
    logic [12:0] ctl;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic mr, input logic rn, input logic sp,
                             input logic [31:0] irv, input logic [12:0] ctl,
                             input logic [15:0] rin, input logic [15:0] rout,
                             input logic [4:0] alu, input logic [3:0] cnt);
    vec_t r;
    r.mr = mr; r.rn = rn; r.sp = sp; r.irv = irv; r.ctl = ctl;
    r.rin = rin; r.rout = rout; r.alu = alu; r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [12:0] ctl_now();
    return {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin,
            Yin, Zin, IncPC, Read, halted, illegal};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [12:0] ctl,
                           input logic [15:0] rin, input logic [15:0] rout,
                           input logic [4:0] alu, input logic [3:0] cnt);
    check({tag, "_ctl"},  32'(ctl_now()),   32'(ctl));
    check({tag, "_rin"},  32'(rin_sel),     32'(rin));
    check({tag, "_rout"}, 32'(rout_sel),    32'(rout));
    check({tag, "_alu"},  32'(alu_op),      32'(alu));
    check({tag, "_cnt"},  32'(instr_count), 32'(cnt));
  endtask

  initial begin
    clear = 1'b1; ir = 32'h0; mem_ready = 1'b0; run = 1'b0; stop = 1'b0;

    // and R1,R2,R3 with no wait states
    vq.push_back(v(1, 0, 0, IR_AND, C_T0,  16'h0000, 16'h0000, 5'd0, 4'd0));
    vq.push_back(v(1, 0, 0, IR_AND, C_T1F, 16'h0000, 16'h0000, 5'd0, 4'd0));
    vq.push_back(v(1, 0, 0, IR_AND, C_T2,  16'h0000, 16'h0000, 5'd0, 4'd0));
    vq.push_back(v(1, 0, 0, IR_AND, C_T3,  16'h0000, 16'h0004, 5'd0, 4'd0));
    vq.push_back(v(1, 0, 0, IR_AND, C_T4,  16'h0000, 16'h0008, OP_AND, 4'd0));
    vq.push_back(v(1, 0, 0, IR_AND, C_T5,  16'h0002, 16'h0000, 5'd0, 4'd0));
    vq.push_back(v(1, 0, 0, IR_AND, C_T0,  16'h0000, 16'h0000, 5'd0, 4'd1));
    // add R4,R5,R6 with three wait cycles in T1
    vq.push_back(v(0, 0, 0, IR_ADD, C_T1F, 16'h0000, 16'h0000, 5'd0, 4'd1));
    vq.push_back(v(0, 0, 0, IR_ADD, C_T1,  16'h0000, 16'h0000, 5'd0, 4'd1));
    vq.push_back(v(0, 0, 0, IR_ADD, C_T1,  16'h0000, 16'h0000, 5'd0, 4'd1));
    vq.push_back(v(0, 0, 0, IR_ADD, C_T1,  16'h0000, 16'h0000, 5'd0, 4'd1));
    vq.push_back(v(1, 0, 0, IR_ADD, C_T2,  16'h0000, 16'h0000, 5'd0, 4'd1));
    vq.push_back(v(1, 0, 0, IR_ADD, C_T3,  16'h0000, 16'h0020, 5'd0, 4'd1));
    vq.push_back(v(1, 0, 0, IR_ADD, C_T4,  16'h0000, 16'h0040, OP_ADD, 4'd1));
    vq.push_back(v(1, 0, 0, IR_ADD, C_T5,  16'h0010, 16'h0000, 5'd0, 4'd1));
    vq.push_back(v(1, 0, 0, IR_ADD, C_T0,  16'h0000, 16'h0000, 5'd0, 4'd2));
    // halt opcode, idle in HALT, then run
    vq.push_back(v(1, 0, 0, IR_HALT, C_T1F,  16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_HALT, C_T2,   16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_HALT, C_NONE, 16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_HALT, C_HALT, 16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_HALT, C_HALT, 16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 1, 0, IR_HALT, C_T0,   16'h0000, 16'h0000, 5'd0, 4'd2));
    // undefined opcode 11111
    vq.push_back(v(1, 0, 0, IR_BAD, C_T1F, 16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_BAD, C_T2,  16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_BAD, C_ILL, 16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_BAD, C_T0,  16'h0000, 16'h0000, 5'd0, 4'd2));
    // stop pulse during T1 of sub R7,R8,R9
    vq.push_back(v(1, 0, 0, IR_SUB, C_T1F,  16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 1, IR_SUB, C_T2,   16'h0000, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_SUB, C_T3,   16'h0000, 16'h0100, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_SUB, C_T4,   16'h0000, 16'h0200, OP_SUB, 4'd2));
    vq.push_back(v(1, 0, 0, IR_SUB, C_T5,   16'h0080, 16'h0000, 5'd0, 4'd2));
    vq.push_back(v(1, 0, 0, IR_SUB, C_HALT, 16'h0000, 16'h0000, 5'd0, 4'd3));
    // run and stop together: exactly one more instruction, or R10,R11,R12
    vq.push_back(v(1, 1, 1, IR_OR, C_T0,   16'h0000, 16'h0000, 5'd0, 4'd3));
    vq.push_back(v(1, 0, 0, IR_OR, C_T1F,  16'h0000, 16'h0000, 5'd0, 4'd3));
    vq.push_back(v(1, 0, 0, IR_OR, C_T2,   16'h0000, 16'h0000, 5'd0, 4'd3));
    vq.push_back(v(1, 0, 0, IR_OR, C_T3,   16'h0000, 16'h0800, 5'd0, 4'd3));
    vq.push_back(v(1, 0, 0, IR_OR, C_T4,   16'h0000, 16'h1000, OP_OR, 4'd3));
    vq.push_back(v(1, 0, 0, IR_OR, C_T5,   16'h0400, 16'h0000, 5'd0, 4'd3));
    vq.push_back(v(1, 0, 0, IR_OR, C_HALT, 16'h0000, 16'h0000, 5'd0, 4'd4));

    #12;
    check_all("reset", C_NONE, 16'h0, 16'h0, 5'd0, 4'd0);
    step();
    check_all("reset_held", C_NONE, 16'h0, 16'h0, 5'd0, 4'd0);
    @(negedge clock);
    clear = 1'b0;

    foreach (vq[i]) begin
      mem_ready = vq[i].mr;
      run       = vq[i].rn;
      stop      = vq[i].sp;
      ir        = vq[i].irv;
      step();
      check_all($sformatf("v%0d", i), vq[i].ctl, vq[i].rin, vq[i].rout,
                vq[i].alu, vq[i].cnt);
    end
    run = 1'b0; stop = 1'b0;

    // clear rising in T4 aborts with no register write
    ir = IR_AND; mem_ready = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    repeat (4) step();
    check_all("pre_abort_t4", C_T4, 16'h0, 16'h0008, OP_AND, 4'd4);
    #2 clear = 1'b1;
    #1;
    check_all("abort_async", C_NONE, 16'h0, 16'h0, 5'd0, 4'd0);
    step();
    check_all("abort_held", C_NONE, 16'h0, 16'h0, 5'd0, 4'd0);
    clear = 1'b0;
    step();
    check_all("abort_restart", C_T0, 16'h0, 16'h0, 5'd0, 4'd0);

    // counter wrap across 2^CNT_W retired instructions
    for (int n = 1; n <= 16; n++) begin
      repeat (6) step();
      check($sformatf("wrap_cnt%0d", n), 32'(instr_count), 32'(n % 16));
    end
    check("wrap_state_t0", 32'(ctl_now()), 32'(C_T0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
